// File: rtl/pi_run_controller_pkg.sv
// Shared types and constants for the pi run controller and its divider.
package pi_run_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SEED,
        ST_RUN,
        ST_CHECK,
        ST_DIV,
        ST_DONE
    } state_t;

    localparam int                 Q_WIDTH       = 32;
    localparam int                 FRAC_BITS_DEF = 28;
    localparam logic [Q_WIDTH-1:0] PI_Q_SATURATE = 32'hFFFF_FFFF;

endpackage

// File: rtl/pi_run_controller_seq_divider.sv
// Radix-2 restoring divider: 64-bit numerator by 32-bit divisor, 32-bit quotient,
// one quotient bit per cycle starting on the cycle i_start is sampled.
module seq_divider (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [63:0] i_num,
    input  logic [31:0] i_den,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quot
);

    logic [32:0] r_rem;
    logic [31:0] r_num;
    logic [31:0] r_q;
    logic [4:0]  r_idx;
    logic        r_busy;
    logic        r_done;

    logic [32:0] w_rem_cur;
    logic        w_bit;
    logic [32:0] w_sh;
    logic        w_ge;
    logic [32:0] w_rem_nx;

    // The high numerator word seeds the remainder, so bit 31 is resolved on the
    // start cycle itself; the high word is below the divisor whenever the quotient fits.
    always_comb begin
        w_rem_cur = i_start ? {1'b0, i_num[63:32]} : r_rem;
        w_bit     = i_start ? i_num[31] : r_num[r_idx];
        w_sh      = (w_rem_cur << 1) | {32'b0, w_bit};
        w_ge      = (w_sh >= {1'b0, i_den});
        w_rem_nx  = w_ge ? (w_sh - {1'b0, i_den}) : w_sh;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem  <= '0;
            r_num  <= '0;
            r_q    <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_nx;
                r_num  <= i_num[31:0];
                r_q    <= {31'b0, w_ge};
                r_idx  <= 5'd30;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nx;
                r_q   <= {r_q[30:0], w_ge};
                if (r_idx == 5'd0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx - 5'd1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_q;

endmodule

// File: rtl/pi_run_controller.sv
// Sequences one estimator run (clear, seed, run) and converts the hit count
// into a Q4.28 pi estimate via the sequential divider.
module pi_run_controller
    import pi_run_controller_pkg::*;
#(
    parameter logic [31:0] N_SAMPLES      = 32'd1000,
    parameter int          FRAC_BITS      = FRAC_BITS_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [31:0]        i_seed_in,
    output logic               o_est_reset,
    output logic               o_est_set_seed,
    output logic [31:0]        o_est_seed,
    output logic               o_est_enable,
    input  logic [31:0]        i_est_result,
    input  logic               i_est_done,
    output logic               o_busy,
    output logic [Q_WIDTH-1:0] o_pi_q,
    output logic               o_pi_valid,
    output logic               o_err
);

    state_t              r_state;
    logic                r_est_reset;
    logic                r_set_seed;
    logic                r_enable;
    logic [31:0]         r_seed;
    logic [31:0]         r_hits;
    logic [31:0]         r_tmo;
    logic [Q_WIDTH-1:0]  r_pi_q;
    logic                r_pi_valid;
    logic                r_err;

    logic                w_div_start;
    logic [63:0]         w_num;
    logic                w_div_busy;
    logic                w_div_done;
    logic [31:0]         w_quot;

    // 4 * hits * 2^FRAC_BITS folded into a single shift
    assign w_num       = {32'b0, r_hits} << (FRAC_BITS + 2);
    assign w_div_start = (r_state == ST_CHECK) && (r_hits <= N_SAMPLES);

    seq_divider u_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_div_start),
        .i_num   (w_num),
        .i_den   (N_SAMPLES),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_est_reset <= 1'b1;
            r_set_seed  <= 1'b0;
            r_enable    <= 1'b0;
            r_seed      <= '0;
            r_hits      <= '0;
            r_tmo       <= '0;
            r_pi_q      <= '0;
            r_pi_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pi_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_est_reset <= 1'b0;
                    if (i_start) begin
                        r_seed      <= i_seed_in;
                        r_err       <= 1'b0;
                        r_est_reset <= 1'b1;
                        r_state     <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    r_est_reset <= 1'b0;
                    r_set_seed  <= 1'b1;
                    r_state     <= ST_SEED;
                end
                ST_SEED: begin
                    r_set_seed <= 1'b0;
                    r_enable   <= 1'b1;
                    r_tmo      <= '0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    // completion takes priority over a coincident timeout
                    if (i_est_done) begin
                        r_hits   <= i_est_result;
                        r_enable <= 1'b0;
                        r_state  <= ST_CHECK;
                    end else if (r_tmo == TIMEOUT_CYCLES - 32'd1) begin
                        r_err      <= 1'b1;
                        r_pi_q     <= '0;
                        r_pi_valid <= 1'b1;
                        r_enable   <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                ST_CHECK: begin
                    if (r_hits > N_SAMPLES) begin
                        r_err      <= 1'b1;
                        r_pi_q     <= PI_Q_SATURATE;
                        r_pi_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_pi_q     <= w_quot;
                        r_pi_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_est_reset    = r_est_reset;
    assign o_est_set_seed = r_set_seed;
    assign o_est_seed     = r_seed;
    assign o_est_enable   = r_enable;
    assign o_busy         = (r_state != ST_IDLE) || w_div_busy;
    assign o_pi_q         = r_pi_q;
    assign o_pi_valid     = r_pi_valid;
    assign o_err          = r_err;

endmodule

// File: tb/tb_pi_run_controller.sv
// Directed + randomized bench for pi_run_controller with an estimator stub
// and an arithmetic reference for the expected pi value.
module tb_pi_run_controller;

    localparam logic [31:0] N   = 32'd1000;
    localparam logic [31:0] TMO = 32'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed_in;
    logic        est_reset;
    logic        est_set_seed;
    logic [31:0] est_seed;
    logic        est_enable;
    logic [31:0] est_result;
    logic        est_done;
    logic        busy;
    logic [31:0] pi_q;
    logic        pi_valid;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    pi_run_controller #(
        .N_SAMPLES      (N),
        .FRAC_BITS      (28),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_seed_in      (seed_in),
        .o_est_reset    (est_reset),
        .o_est_set_seed (est_set_seed),
        .o_est_seed     (est_seed),
        .o_est_enable   (est_enable),
        .i_est_result   (est_result),
        .i_est_done     (est_done),
        .o_busy         (busy),
        .o_pi_q         (pi_q),
        .o_pi_valid     (pi_valid),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    // floor(4 * hits * 2^28 / N), saturated when hits exceed the sample count
    function automatic logic [31:0] ref_pi(input logic [31:0] h);
        logic [63:0] p;
        if (h > N) return 32'hFFFF_FFFF;
        p = (64'(h) * 64'd4 * 64'd268435456) / 64'(N);
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_run(input logic [31:0] seed, input int dly, input logic [31:0] hits,
                          input bit never_done, input bit poke, input bit mid_reset);
        int k;
        bit over;
        over = (hits > N);
        @(negedge clk); start = 1'b1; seed_in = seed;
        @(negedge clk); start = 1'b0; seed_in = $urandom;
        chk("clr_est_reset", est_reset, 1);
        chk("clr_err", err, 0);
        chk("clr_busy", busy, 1);
        @(negedge clk);
        chk("seed_pulse", est_set_seed, 1);
        chk("seed_value", est_seed, seed);
        chk("seed_enable_low", est_enable, 0);
        @(negedge clk);
        chk("run_enable", est_enable, 1);
        if (never_done) begin
            k = 0;
            while (est_enable === 1'b1 && k < 100) begin
                k++;
                @(negedge clk);
            end
            chk("tmo_enable_cycles", k, 16);
            chk("tmo_valid", pi_valid, 1);
            chk("tmo_err", err, 1);
            chk("tmo_pi_q", pi_q, 0);
        end else begin
            for (int i = 0; i < dly; i++) begin
                start = poke && (i == 0);
                @(negedge clk);
            end
            start = 1'b0; est_done = 1'b1; est_result = hits;
            @(negedge clk);
            est_done = 1'b0; est_result = $urandom;
            chk("check_enable_low", est_enable, 0);
            k = 1;
            while (pi_valid !== 1'b1 && k < 60) begin
                if (mid_reset && k == 15) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    chk("rst_busy", busy, 0);
                    chk("rst_valid", pi_valid, 0);
                    chk("rst_pi_q", pi_q, 0);
                    chk("rst_est_reset", est_reset, 1);
                    chk("rst_enable", est_enable, 0);
                    return;
                end
                start = poke && (k == 10);
                @(negedge clk);
                k++;
            end
            start = 1'b0;
            chk("latency", k, over ? 2 : 34);
            chk("pi_q", pi_q, ref_pi(hits));
            chk("err", err, over);
        end
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("valid_single", pi_valid, 0);
        chk("idle_busy", busy, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("no_queued_run", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seed_in = '0; est_result = '0; est_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_est_reset", est_reset, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pi_q", pi_q, 0);
        chk("reset_valid", pi_valid, 0);
        chk("reset_err", err, 0);
        chk("reset_enable", est_enable, 0);
        chk("reset_set_seed", est_set_seed, 0);
        chk("reset_seed", est_seed, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_est_reset", est_reset, 0);

        // completion outside RUN must not start anything
        est_done = 1'b1; est_result = 32'd5;
        @(negedge clk);
        est_done = 1'b0;
        @(negedge clk);
        chk("stray_done_busy", busy, 0);
        chk("stray_done_valid", pi_valid, 0);

        do_run(32'hDEADBEEF, 3, 32'd785, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 1, 32'd1000, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 2, 32'd1001, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", err, 1);
        do_run($urandom, 5, 32'd500, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 0, 32'd0, 1'b1, 1'b0, 1'b0);
        do_run($urandom, 15, 32'd900, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 4, 32'd333, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++)
            do_run($urandom, int'($urandom_range(0, 15)), $urandom_range(0, 1100), 1'b0, 1'b0, 1'b0);

        do_run($urandom, 1, 32'd785, 1'b0, 1'b0, 1'b0);
        do_run($urandom, 2, 32'd785, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_est_reset", est_reset, 0);
        do_run($urandom, 6, 32'd999, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
